uart_rx: RTL



---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_if.sv | 26 ++
 rtl/uart_sync.sv | 21 ++
 rtl/uart_rx.sv | 134 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state type and baud-derived constant helpers.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    function automatic int unsigned pulse_width(input int unsigned clk_freq,
                                                input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int unsigned half_pulse_width(input int unsigned clk_freq,
                                                     input int unsigned baud_rate);
        return pulse_width(clk_freq, baud_rate) / 2;
    endfunction

    function automatic int unsigned baud_cnt_width(input int unsigned clk_freq,
                                                   input int unsigned baud_rate);
        return $clog2(pulse_width(clk_freq, baud_rate)) + 1;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side word handshake: data/valid out, ready in, plus error pulses.
interface uart_rx_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;
    logic                  frame_err;
    logic                  overrun;

    modport master (
        output data,
        output valid,
        output frame_err,
        output overrun,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  frame_err,
        input  overrun,
        output ready
    );
endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer with a parameterized reset level (async active-high reset).
module uart_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver with valid/ready output and one-cycle error pulses.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting at every sample point (PULSE_WIDTH >= 6).
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned CLK_FREQ   = 12_000_000
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     sig,
    uart_rx_if.master rx
);
    localparam int unsigned PULSE_WIDTH      = pulse_width(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF_PULSE_WIDTH = half_pulse_width(CLK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W            = baud_cnt_width(CLK_FREQ, BAUD_RATE);
    localparam int unsigned IDX_W            = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_PULSE_WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    rx_state_t             state;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  sig_s;
    logic                  sig_prev;
    logic                  sample_now;
    logic                  bit_val;

    uart_sync #(.RESET_VALUE(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sig),
        .q   (sig_s)
    );

    assign sample_now = (cnt == '0);

`ifdef UART_RX_MAJORITY_EN
    // Early votes are captured at cnt==2 and cnt==1 so the decision still lands at cnt==0.
    logic vote_2;
    logic vote_1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote_2 <= 1'b1;
            vote_1 <= 1'b1;
        end else if (state != IDLE) begin
            if (cnt == CNT_W'(2)) vote_2 <= sig_s;
            if (cnt == CNT_W'(1)) vote_1 <= sig_s;
        end
    end

    assign bit_val = majority3(vote_2, vote_1, sig_s);
`else
    assign bit_val = sig_s;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            sig_prev     <= 1'b1;
            rx.data      <= '0;
            rx.valid     <= 1'b0;
            rx.frame_err <= 1'b0;
            rx.overrun   <= 1'b0;
        end else begin
            sig_prev     <= sig_s;
            rx.frame_err <= 1'b0;
            rx.overrun   <= 1'b0;

            if (rx.valid && rx.ready) rx.valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (sig_prev && !sig_s) begin
                        cnt   <= CNT_HALF;
                        state <= START;
                    end
                end

                START: begin
                    if (sample_now) begin
                        if (bit_val) begin
                            state <= IDLE;
                        end else begin
                            cnt     <= CNT_FULL;
                            bit_idx <= '0;
                            state   <= DATA;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                DATA: begin
                    if (sample_now) begin
                        shreg[bit_idx] <= bit_val;
                        cnt            <= CNT_FULL;
                        if (bit_idx == IDX_LAST) state <= STOP;
                        else                     bit_idx <= bit_idx + IDX_W'(1);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                STOP: begin
                    if (sample_now) begin
                        state <= IDLE;
                        if (!bit_val) begin
                            rx.frame_err <= 1'b1;
                        end else if (!rx.valid || rx.ready) begin
                            // A same-cycle handshake frees the slot, so the new word wins over the clear above.
                            rx.data  <= shreg;
                            rx.valid <= 1'b1;
                        end else begin
                            rx.overrun <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
